// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-master MemSplit32 arbiter.
// Master IDs are one bit wide; they are what the read-ID FIFO stores.
package arb_pkg;
    typedef logic [0:0] mst_id_t;

    localparam mst_id_t MST_M0 = 1'b0;
    localparam mst_id_t MST_M1 = 1'b1;

    localparam int RD_DEPTH_DEF = 4;
endpackage

// File: rtl/arb_m2_if.sv
// MemSplit32 request/response bus: req/we/addr/be/wdata downstream, ack/resp/rdata upstream.
// The master modport drives requests; the slave modport answers them.
interface arb_m2_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of issuing-master IDs for outstanding reads; output is the head, zero read latency.
// Pushes while full and pops while empty are ignored; pointers and count reset asynchronously.
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] id_i,
    input  logic         pop_i,
    output logic [W-1:0] id_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign id_o    = mem_q[rd_ptr_q];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/arb_m2.sv
// Two-master to one-slave MemSplit32 arbiter; zero added latency, round-robin grant, reads routed back via an ID FIFO.
// Loser and FIFO-blocked reads see ack=0 and must hold. ARB_M2_FIXED_PRIO_EN selects fixed m0 priority.
module arb_m2
    import arb_pkg::*;
#(
    parameter int RD_DEPTH = RD_DEPTH_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    arb_m2_if.slave  m0,
    arb_m2_if.slave  m1,
    arb_m2_if.master s
);
    mst_id_t win;
    mst_id_t head_id;
    logic    any_req;
    logic    win_we;
    logic    fwd_req;
    logic    accept;
    logic    fifo_full;
    logic    fifo_empty;
    logic    resp_vld;

    assign any_req = m0.req || m1.req;

`ifdef ARB_M2_FIXED_PRIO_EN
    always_comb begin
        win = MST_M0;
        if (m1.req && !m0.req) begin
            win = MST_M1;
        end
    end
`else
    mst_id_t rr_last;

    always_comb begin
        win = MST_M0;
        if (m0.req && m1.req) begin
            win = ~rr_last;
        end else if (m1.req) begin
            win = MST_M1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last <= MST_M1;
        end else if (accept) begin
            rr_last <= win;
        end
    end
`endif

    assign win_we = (win == MST_M1) ? m1.we : m0.we;
    // Blocking looks only at the registered count, so resp never reaches ack combinationally.
    assign fwd_req = any_req && (win_we || !fifo_full);
    assign accept  = fwd_req && s.ack;

    always_comb begin
        s.req   = fwd_req;
        s.we    = 1'b0;
        s.addr  = '0;
        s.be    = '0;
        s.wdata = '0;
        if (any_req) begin
            s.we    = win_we;
            s.addr  = (win == MST_M1) ? m1.addr  : m0.addr;
            s.be    = (win == MST_M1) ? m1.be    : m0.be;
            s.wdata = (win == MST_M1) ? m1.wdata : m0.wdata;
        end
    end

    assign m0.ack = accept && (win == MST_M0);
    assign m1.ack = accept && (win == MST_M1);

    arb_id_fifo #(
        .DEPTH (RD_DEPTH),
        .W     (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept && !win_we),
        .id_i    (win),
        .pop_i   (s.resp),
        .id_o    (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A response with nothing outstanding belongs to no one and is dropped.
    assign resp_vld = s.resp && !fifo_empty;

    assign m0.resp  = resp_vld && (head_id == MST_M0);
    assign m1.resp  = resp_vld && (head_id == MST_M1);
    assign m0.rdata = m0.resp ? s.rdata : '0;
    assign m1.rdata = m1.resp ? s.rdata : '0;
endmodule

// File: tb/tb_arb_m2.sv
// Directed scoreboard bench for arb_m2: stimulus queues expected grants and responses, a monitor checks them.
module tb_arb_m2;
    import arb_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    arb_m2_if m0_if ();
    arb_m2_if m1_if ();
    arb_m2_if s_if ();

    arb_m2 #(.RD_DEPTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    int checks   = 0;
    int failures = 0;

    mst_id_t     exp_ack [$];
    mst_id_t     exp_rsp_mst [$];
    logic [31:0] exp_rsp_dat [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] fifo_count();
        return 32'(dut.u_id_fifo.count_q);
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.be = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.be = '0; m1_if.wdata = '0;
        s_if.ack = 1'b0; s_if.resp = 1'b0; s_if.rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: every grant and every response the DUT presents is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (m0_if.ack && m1_if.ack) begin
                checks++; failures++;
                $display("FAIL dual_ack actual=both required=one");
            end else if (m0_if.ack || m1_if.ack) begin
                if (exp_ack.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack actual=m%0d required=none", m1_if.ack);
                end else begin
                    chk("grant", 32'(m1_if.ack), 32'(exp_ack.pop_front()));
                end
            end
            if (m0_if.resp && m1_if.resp) begin
                checks++; failures++;
                $display("FAIL dual_resp actual=both required=one");
            end else if (m0_if.resp || m1_if.resp) begin
                if (exp_rsp_mst.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp actual=m%0d required=none", m1_if.resp);
                end else begin
                    chk("resp_master", 32'(m1_if.resp), 32'(exp_rsp_mst.pop_front()));
                    chk("resp_rdata", m1_if.resp ? m1_if.rdata : m0_if.rdata, exp_rsp_dat.pop_front());
                    chk("resp_other_rdata", m1_if.resp ? m0_if.rdata : m1_if.rdata, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr;
        mst_id_t     w;

        // Reset state
        clear_inputs();
        #1;
        chk("rst_s_req", 32'(s_if.req), 32'h0);
        chk("rst_acks", {30'h0, m1_if.ack, m0_if.ack}, 32'h0);
        chk("rst_resps", {30'h0, m1_if.resp, m0_if.resp}, 32'h0);
        chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
        chk("rst_count", fifo_count(), 32'h0);
        apply_reset();

        // 1: single master read, response two cycles after accept
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h100; m0_if.be = 4'hF;
        s_if.ack = 1'b1;
        exp_ack.push_back(MST_M0);
        #1;
        chk("t1_s_addr", s_if.addr, 32'h100);
        chk("t1_s_req", 32'(s_if.req), 32'h1);
        cyc();
        m0_if.req = 1'b0; s_if.ack = 1'b0;
        chk("t1_count", fifo_count(), 32'h1);
        cyc();
        s_if.resp = 1'b1; s_if.rdata = 32'hDEADBEEF;
        exp_rsp_mst.push_back(MST_M0); exp_rsp_dat.push_back(32'hDEADBEEF);
        cyc();
        s_if.resp = 1'b0; s_if.rdata = '0;
        cyc();

        // 2: contention, both masters write every cycle
        apply_reset();
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'hA0;
        m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'hB0;
        s_if.ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_M2_FIXED_PRIO_EN
            w = MST_M0;
`else
            w = (i % 2 == 0) ? MST_M0 : MST_M1;
`endif
            exp_ack.push_back(w);
            exp_addr = (w == MST_M1) ? 32'hB0 : 32'hA0;
            #1;
            chk($sformatf("t2_s_addr_%0d", i), s_if.addr, exp_addr);
            cyc();
        end
        clear_inputs();
        cyc();

        // 3: interleaved reads from m0 then m1, responses in order
        s_if.ack = 1'b1;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h200;
        exp_ack.push_back(MST_M0);
        cyc();
        m0_if.req = 1'b0;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h300;
        exp_ack.push_back(MST_M1);
        cyc();
        m1_if.req = 1'b0; s_if.ack = 1'b0;
        cyc();
        s_if.resp = 1'b1; s_if.rdata = 32'h1111;
        exp_rsp_mst.push_back(MST_M0); exp_rsp_dat.push_back(32'h1111);
        cyc();
        s_if.rdata = 32'h2222;
        exp_rsp_mst.push_back(MST_M1); exp_rsp_dat.push_back(32'h2222);
        cyc();
        s_if.resp = 1'b0; s_if.rdata = '0;
        cyc();

        // 4: FIFO full blocks reads but not writes
        s_if.ack = 1'b1;
        m0_if.req = 1'b1; m0_if.we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_if.addr = 32'h400 + 32'(i * 4);
            exp_ack.push_back(MST_M0);
            cyc();
        end
        m0_if.addr = 32'h410;
        #1;
        chk("t4_full_count", fifo_count(), 32'h4);
        chk("t4_blocked_s_req", 32'(s_if.req), 32'h0);
        chk("t4_blocked_ack", 32'(m0_if.ack), 32'h0);
        cyc();
        m0_if.we = 1'b1;
        exp_ack.push_back(MST_M0);
        #1;
        chk("t4_write_s_req", 32'(s_if.req), 32'h1);
        cyc();
        m0_if.we = 1'b0;
        s_if.resp = 1'b1; s_if.rdata = 32'hC0;
        exp_rsp_mst.push_back(MST_M0); exp_rsp_dat.push_back(32'hC0);
        #1;
        chk("t4_pop_cycle_s_req", 32'(s_if.req), 32'h0);
        cyc();
        s_if.resp = 1'b0;
        exp_ack.push_back(MST_M0);
        #1;
        chk("t4_unblocked_ack", 32'(m0_if.ack), 32'h1);
        cyc();
        m0_if.req = 1'b0; s_if.ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_if.resp = 1'b1; s_if.rdata = 32'hC1 + 32'(i);
            exp_rsp_mst.push_back(MST_M0); exp_rsp_dat.push_back(32'hC1 + 32'(i));
            cyc();
        end
        s_if.resp = 1'b0;
        chk("t4_drained_count", fifo_count(), 32'h0);

        // 5: spurious response with empty FIFO
        s_if.resp = 1'b1; s_if.rdata = 32'h5555;
        #1;
        chk("t5_resps", {30'h0, m1_if.resp, m0_if.resp}, 32'h0);
        chk("t5_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
        cyc();
        s_if.resp = 1'b0; s_if.rdata = '0;
        chk("t5_count", fifo_count(), 32'h0);

        // 6: async reset with two reads outstanding
        s_if.ack = 1'b1;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h600;
        exp_ack.push_back(MST_M0);
        cyc();
        m0_if.req = 1'b0;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h700;
        exp_ack.push_back(MST_M1);
        cyc();
        m1_if.req = 1'b0; s_if.ack = 1'b0;
        chk("t6_outstanding", fifo_count(), 32'h2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_count", fifo_count(), 32'h0);
        cyc();
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_if.resp = 1'b1; s_if.rdata = 32'h6000 + 32'(i);
            #1;
            chk($sformatf("t6_dropped_resp_%0d", i), {30'h0, m1_if.resp, m0_if.resp}, 32'h0);
            cyc();
        end
        s_if.resp = 1'b0;
        cyc();

        chk("leftover_ack", 32'(exp_ack.size()), 32'h0);
        chk("leftover_resp", 32'(exp_rsp_mst.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arb_m2.md
Name: arb_m2

Overview:
- 2-master to 1-slave arbiter on the MemSplit32 bus; the converging counterpart of the L2 address-decode splitter.
- Merges requests from two initiators (e.g. instruction and data ports of a core, or two cores) onto one memory/L2 port.
- Round-robin grant on each accepted request.
- Per-read source tracking in an in-order ID FIFO, so read responses return to the issuing master while multiple reads are outstanding.

Parameters:
- RD_DEPTH, 4, max outstanding reads tracked; power of two, 2..16.
- CNT_W, $clog2(RD_DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- m0  MemSplit32.Slave  -  master 0 port. Signals: req, we, addr[31:0], be[3:0], wdata[31:0] in; ack, resp, rdata[31:0] out.
- m1  MemSplit32.Slave  -  master 1 port, same signals as m0.
- s  MemSplit32.Master  -  downstream slave port. Drives req/we/addr/be/wdata; receives ack/resp/rdata.

Behaviour:
- Handshake: a request transfers in the cycle where req && ack. A read response is a 1-cycle resp pulse with rdata valid. Responses arrive in request order, at least 1 cycle after ack.
- Reset (rst_ni=0, async): rr_last=1 (so m0 has first priority), FIFO wr_ptr=rd_ptr=0, count=0. All outputs are combinational and evaluate to 0 while no request is pending: s.req=0, m0/m1.ack=0, m0/m1.resp=0, rdata=0.
- Grant is combinational each cycle:
  - only one requester: it wins.
  - both request: the master not equal to rr_last wins.
- Winner's req/we/addr/be/wdata are forwarded to s. The loser sees ack=0 and must hold its request.
- s.ack is routed to the winner's ack only; the other master's ack=0.
- Read blocking: if the winner's we=0 and count==RD_DEPTH, then s.req=0 and the winner's ack=0.
  - A pop in the same cycle does not unblock; this keeps resp→ack combinational paths out.
- Writes are never blocked by the FIFO.
- rr_last update: on an accepted transfer, rr_last <= winner. Otherwise rr_last holds.
- Push: an accepted read (s.req && s.ack && !we) pushes the winner ID (1 bit) and increments wr_ptr.
- Pop: s.resp pops the head ID and increments rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: pointers are log2(RD_DEPTH) bits and wrap modulo RD_DEPTH.
- Response routing: m[head].resp = s.resp and m[head].rdata = s.rdata. The other master gets resp=0, rdata=0.
- Empty-FIFO response: s.resp with count==0 is dropped; no master sees resp and no state changes.
- Masters may issue new requests while their own reads are outstanding; ordering is preserved by the FIFO.
- Latency: zero added cycles; request and response paths are combinational through the block.
- Reset mid-transaction: outstanding IDs are discarded and later responses are dropped. The system must reset the downstream slave together with the arbiter.

Optional Feature:
- Macro ARB_M2_FIXED_PRIO_EN.
- Defined: m0 always wins when both masters request; rr_last flop is removed. m1 can starve; this mode is for a latency-critical instruction port.
- Undefined: round-robin as specified above.

Decomposition:
- Package arb_pkg:
  - typedef logic [0:0] mst_id_t
  - localparam MST_M0=1'b0, MST_M1=1'b1
  - RD_DEPTH default constant
- Sub-module arb_id_fifo (params DEPTH, W):
  - ports clk_i, rst_ni, push_i, id_i, pop_i, id_o, full_o, empty_o.
  - Register-array FIFO with async reset of pointers and count.
- arb_m2 instantiates arb_id_fifo once and contains the grant, mux and route logic.

Test Plan:
1. Single master: m0 reads 0x100 while s acks immediately and returns resp 2 cycles later with rdata 0xDEADBEEF → m0.ack in cycle 0; m0.resp pulses with 0xDEADBEEF; m1.resp stays 0.
2. Contention: m0 and m1 both request continuously, s.ack=1 every cycle → grants alternate m0, m1, m0, m1 starting with m0 after reset. With ARB_M2_FIXED_PRIO_EN, grants are m0 every cycle.
3. Interleaved reads: m0 reads A, then m1 reads B; s responds 0x1111 then 0x2222 → m0 receives 0x1111, m1 receives 0x2222, each as a single resp pulse.
4. FIFO full: RD_DEPTH=4; issue 4 reads with no resp, then a 5th read → 5th is held (ack=0, s.req=0). A write issued in the same state is acked. After one s.resp, the 5th read is acked in the following cycle.
5. Spurious resp: s.resp=1 with an empty FIFO → neither master sees resp; count stays 0.
6. Async reset: drop rst_ni mid-cycle with 2 reads outstanding → count=0 immediately with no clock edge needed. The following resp pulses are dropped.
